// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module   : adder_arb_pkg
// Purpose  : Shared sizes and FSM encoding for the 4-channel arbitrated adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/adder_8bit.sv
// ============================================================================
// Module   : adder_8bit
// Purpose  : Combinational adder producing sum and carry-out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_8bit #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] sum_out,
  output logic              carry_out
);

  assign {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_in};

endmodule

`default_nettype wire

// File: rtl/adder_arbiter_4ch.sv
// ============================================================================
// Module   : adder_arbiter_4ch
// Purpose  : Round-robin arbiter sharing one adder among four requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_arbiter_4ch
  import adder_arb_pkg::*;
#(
  parameter int N_REQ  = adder_arb_pkg::N_REQ,
  parameter int DATA_W = adder_arb_pkg::DATA_W
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [N_REQ-1:0]          req_in,
  input  logic [N_REQ*DATA_W-1:0]   a_in,
  input  logic [N_REQ*DATA_W-1:0]   b_in,
  output logic [N_REQ-1:0]          gnt_out,
  output logic                      res_valid_out,
  input  logic                      res_ready_in,
  output logic [$clog2(N_REQ)-1:0]  res_id_out,
  output logic [DATA_W-1:0]         sum_out,
  output logic                      carry_out,
  output logic [15:0]               op_count_out
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t              r_state;
  state_t              w_next_state;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_valid;
  logic [PTR_W-1:0]    r_id;
  logic [PTR_W-1:0]    r_last_ptr;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_sum;
  logic                r_carry;
  logic [15:0]         r_op_count;

  logic                w_any_req;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_idx;
  logic [N_REQ-1:0]    w_gnt;
  logic [DATA_W-1:0]   w_add_sum;
  logic                w_add_carry;

  // Walk from last_ptr (lowest priority) back towards last_ptr+1 so the
  // closest requester after the previous winner overrides the rest.
  always_comb begin
    w_any_req = |req_in;
    w_win     = r_last_ptr;
    w_idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = r_last_ptr + PTR_W'(k);
      if (req_in[w_idx]) begin
        w_win = w_idx;
      end
    end
    w_gnt = '0;
    w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = CALC;
      CALC:    w_next_state = DONE;
      DONE:    if (res_ready_in) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  adder_8bit #(
    .DATA_W (DATA_W)
  ) u_adder (
    .a_in      (r_op_a),
    .b_in      (r_op_b),
    .sum_out   (w_add_sum),
    .carry_out (w_add_carry)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_last_ptr <= PTR_W'(N_REQ - 1);
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_gnt;
            r_id       <= w_win;
            r_last_ptr <= w_win;
            r_op_a     <= a_in[w_win*DATA_W +: DATA_W];
            r_op_b     <= b_in[w_win*DATA_W +: DATA_W];
          end
        end
        CALC: begin
          r_sum   <= w_add_sum;
          r_carry <= w_add_carry;
          r_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready_in) begin
            r_valid    <= 1'b0;
            r_op_count <= r_op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_out       = r_gnt;
  assign res_valid_out = r_valid;
  assign res_id_out    = r_id;
  assign sum_out       = r_sum;
  assign carry_out     = r_carry;
  assign op_count_out  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter_4ch.sv
// ============================================================================
// Module   : tb_adder_arbiter_4ch
// Purpose  : Directed self-checking bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_arbiter_4ch;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [3:0]  req_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        res_ready_in;
  logic [3:0]  gnt_out;
  logic        res_valid_out;
  logic [1:0]  res_id_out;
  logic [7:0]  sum_out;
  logic        carry_out;
  logic [15:0] op_count_out;

  int checks   = 0;
  int failures = 0;

  adder_arbiter_4ch dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_in        (req_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .gnt_out       (gnt_out),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_id_out    (res_id_out),
    .sum_out       (sum_out),
    .carry_out     (carry_out),
    .op_count_out  (op_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Transaction model: 0 = waiting for a request, 1 = operands held,
  // 2 = result offered to the consumer.
  int          m_phase = 0;
  int          m_ptr   = 3;
  bit          m_en    = 1'b0;
  logic [3:0]  m_gnt   = '0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_id    = '0;
  logic [7:0]  m_sum   = '0;
  logic        m_carry = 1'b0;
  logic [15:0] m_cnt   = '0;
  int          m_opa   = 0;
  int          m_opb   = 0;

  always @(posedge clk_in) begin
    int w;
    int total;
    bit found;
    if (!rst_n_in) begin
      m_phase = 0; m_ptr = 3; m_gnt = '0; m_valid = 1'b0; m_id = '0;
      m_sum = '0; m_carry = 1'b0; m_cnt = '0;
    end else begin
      m_gnt = '0;
      if (m_phase == 0) begin
        if (req_in != 4'b0) begin
          found = 1'b0;
          w = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && req_in[(m_ptr + k) % 4]) begin
              w = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          m_gnt[w] = 1'b1;
          m_id  = 2'(w);
          m_ptr = w;
          m_opa = int'(a_in[w*8 +: 8]);
          m_opb = int'(b_in[w*8 +: 8]);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        total   = m_opa + m_opb;
        m_sum   = total[7:0];
        m_carry = total[8];
        m_valid = 1'b1;
        m_phase = 2;
      end else begin
        if (res_ready_in) begin
          m_valid = 1'b0;
          m_cnt   = m_cnt + 16'd1;
          m_phase = 0;
        end
      end
    end
    m_en = 1'b1;
  end

  always @(negedge clk_in) begin
    if (m_en) begin
      checks++;
      if ({gnt_out, res_valid_out, res_id_out, sum_out, carry_out, op_count_out} !==
          {m_gnt, m_valid, m_id, m_sum, m_carry, m_cnt}) begin
        failures++;
        $display("FAIL model_cmp t=%0t got gnt=%b v=%b id=%0d sum=%h c=%b cnt=%h exp gnt=%b v=%b id=%0d sum=%h c=%b cnt=%h",
                 $time, gnt_out, res_valid_out, res_id_out, sum_out, carry_out, op_count_out,
                 m_gnt, m_valid, m_id, m_sum, m_carry, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Advance one clock; requesters drop their request once granted.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    req_in = req_in & ~gnt_out;
  endtask

  int g_idx[4];
  int g_cyc[4];
  int n_g;

  initial begin
    rst_n_in = 1'b0; req_in = '0; a_in = '0; b_in = '0; res_ready_in = 1'b1;
    @(negedge clk_in);
    tick(); tick();
    chk("rst_gnt", 32'(gnt_out), 32'h0);
    chk("rst_valid", 32'(res_valid_out), 32'h0);
    chk("rst_sum_carry_id", {21'h0, carry_out, sum_out, res_id_out}, 32'h0);
    chk("rst_cnt", 32'(op_count_out), 32'h0);
    rst_n_in = 1'b1;

    // Single request from requester 0.
    a_in[7:0] = 8'h12; b_in[7:0] = 8'h34; req_in = 4'b0001;
    tick();
    chk("t1_gnt", 32'(gnt_out), 32'h1);
    tick();
    chk("t1_valid", 32'(res_valid_out), 32'h1);
    chk("t1_id", 32'(res_id_out), 32'h0);
    chk("t1_sum", 32'(sum_out), 32'h46);
    chk("t1_carry", 32'(carry_out), 32'h0);
    tick();
    chk("t1_cnt", 32'(op_count_out), 32'h1);

    // All four requesting after a fresh reset.
    rst_n_in = 1'b0; tick(); rst_n_in = 1'b1;
    a_in = 32'h40302010; b_in = 32'h04030201; req_in = 4'b1111;
    n_g = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (gnt_out != 4'b0 && n_g < 4) begin
        for (int j = 0; j < 4; j++) if (gnt_out[j]) g_idx[n_g] = j;
        g_cyc[n_g] = c;
        n_g++;
      end
    end
    chk("t2_ngrants", 32'(n_g), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(g_idx[i]), 32'(i));
    for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    chk("t2_cnt", 32'(op_count_out), 32'd4);

    // Overflow on requester 2.
    a_in[23:16] = 8'hFF; b_in[23:16] = 8'h01; req_in = 4'b0100;
    tick(); tick();
    chk("t3_sum", 32'(sum_out), 32'h0);
    chk("t3_carry", 32'(carry_out), 32'h1);
    chk("t3_id", 32'(res_id_out), 32'h2);
    tick();

    // Back-pressure with requester 3 waiting.
    res_ready_in = 1'b0;
    a_in[7:0] = 8'hAA; b_in[7:0] = 8'h11; req_in = 4'b0001;
    tick();
    chk("t4_gnt0", 32'(gnt_out), 32'h1);
    req_in = 4'b1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold", {22'h0, gnt_out, res_valid_out, carry_out, res_id_out, 2'b0},
                     {22'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b0});
      chk("t4_sum", 32'(sum_out), 32'hBB);
    end
    res_ready_in = 1'b1;
    tick(); tick();
    chk("t4_gnt3", 32'(gnt_out), 32'h8);
    tick(); tick();

    // Reset in the middle of an operation.
    req_in = 4'b0010;
    tick();
    chk("t5_gnt1", 32'(gnt_out), 32'h2);
    rst_n_in = 1'b0;
    tick();
    chk("t5_rst_outs", {22'h0, gnt_out, res_valid_out, carry_out, res_id_out, 2'b0}, 32'h0);
    chk("t5_rst_sum", 32'(sum_out), 32'h0);
    chk("t5_rst_cnt", 32'(op_count_out), 32'h0);
    rst_n_in = 1'b1;
    req_in = 4'b0011;
    tick();
    chk("t5_gnt0", 32'(gnt_out), 32'h1);
    req_in = 4'b0000;
    tick(); tick();
    chk("t5_cnt", 32'(op_count_out), 32'h1);

    // Counter wrap from 0xFFFF.
    #2;
    dut.r_op_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    req_in = 4'b0001;
    tick(); tick(); tick();
    chk("t6_wrap", 32'(op_count_out), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_arbiter_4ch.md
ADDER_ARBITER_4CH -- requirements
Module: adder_arbiter_4ch

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the adder; fixed at 4 in this release.
REQ-002 Parameter DATA_W, default 8: operand and sum width.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, synchronous and active-low.
REQ-005 req_in  input  4  per-requester request; bit i is held high with stable operands until gnt_out[i] is seen.
REQ-006 a_in  input  32  packed operand A; requester i drives bits [8i+7:8i].
REQ-007 b_in  input  32  packed operand B; same packing as a_in.
REQ-008 gnt_out  output  4  registered one-hot grant, high for exactly one cycle per accepted operation.
REQ-009 res_valid_out  output  1  result valid; held until accepted.
REQ-010 res_ready_in  input  1  result consumer ready; transfer when res_valid_out and res_ready_in are both high.
REQ-011 res_id_out  output  2  index of the requester that owns the current result.
REQ-012 sum_out  output  8  result sum, low 8 bits of A+B.
REQ-013 carry_out  output  1  result carry, bit 8 of A+B.
REQ-014 op_count_out  output  16  count of completed result transfers.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-016 IDLE with any req_in bit high: select the winner, capture its A/B, pulse gnt_out[winner], load res_id, go to CALC.
REQ-017 IDLE with req_in zero: stay in IDLE; gnt_out stays zero.
REQ-018 Arbitration SHALL be round-robin: search order last_ptr+1, +2, +3, last_ptr (mod 4); last_ptr updates to the winner on grant.
REQ-019 CALC: register {carry, sum} = A + B at 9-bit width; raise res_valid_out; go to DONE.
REQ-020 DONE: hold res_valid_out, res_id_out, sum_out and carry_out stable until res_ready_in is high.
REQ-021 DONE with res_ready_in high: clear res_valid_out, increment op_count_out, return to IDLE.
REQ-022 Minimum latency from request sampled to res_valid_out high SHALL be 2 cycles; minimum issue interval SHALL be 3 cycles per operation.
REQ-023 req_in SHALL be ignored in CALC and DONE; a request dropped before grant SHALL leave no state behind.
REQ-024 Overflow 0xFF+0x01 SHALL give sum_out 0x00 and carry_out 1; there are no other arithmetic exceptions.
REQ-025 op_count_out SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-026 res_ready_in high while res_valid_out is low SHALL have no effect.

Reset
REQ-027 When rst_n_in is low at a clock edge: state goes to IDLE; gnt_out, res_valid_out, res_id_out, sum_out, carry_out and op_count_out go to 0; last_ptr goes to 3, so requester 0 wins first.
REQ-028 Reset asserted mid-operation (CALC or DONE) SHALL abandon the operation with no result and no count increment.

Structure
REQ-029 Package adder_arb_pkg SHALL hold N_REQ, DATA_W and the state encoding (IDLE=0, CALC=1, DONE=2).
REQ-030 The add SHALL be done by one instance of sub-module adder_8bit (combinational, a/b in, sum/carry out), fed from the captured operand registers.
REQ-031 The round-robin winner logic SHALL be a combinational function of req_in and last_ptr inside this module.

Verification
REQ-032 Reset, then req_in=0001 with A0=0x12, B0=0x34 and res_ready_in=1 -> gnt_out=0001 one cycle later; then res_valid_out=1, res_id_out=0, sum_out=0x46, carry_out=0; op_count_out=1.
REQ-033 req_in=1111 held, each requester drops its request on grant, res_ready_in=1 -> grants in order 0,1,2,3, each 3 cycles apart; op_count_out=4.
REQ-034 A2=0xFF, B2=0x01 -> sum_out=0x00, carry_out=1, res_id_out=2.
REQ-035 res_ready_in=0 for 5 cycles in DONE while req_in=1000 -> outputs stable, gnt_out=0000 throughout; the grant to requester 3 follows release.
REQ-036 rst_n_in low during CALC -> all outputs 0 next cycle and op_count_out unchanged at 0; the next request goes to requester 0.
REQ-037 Preload op_count_out=0xFFFF via 65535 transfers (or force) plus one more transfer -> op_count_out=0x0000.
